aes128_ctrl: RTL and testbench

//  Request sequencer in front of the aes128 core. Accepts {key, data, direction} jobs over valid/ready.

---
 rtl/aes128_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_aes128_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_ctrl.sv
// aes128_ctrl: request sequencer in front of an aes128 core.
// Accepts {key, data, direction} jobs and drives the core's shared 128-bit lane.
// Issues the key and data load pulses in order, then waits for the core's ready flags.
// Returns the result over a valid/ready response port.
// Keeps the last expanded key, so a job that repeats it skips the key schedule.
module aes128_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned CNT_W          = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  // job request
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [127:0] req_key_i,
  input  logic [127:0] req_data_i,
  input  logic         req_dec_i,
  input  logic         req_force_key_i,
  // job response
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [127:0] rsp_data_o,
  output logic         rsp_err_o,
  output logic         busy_o,
  // aes128 core side
  output logic         core_reset_key_o,
  output logic         core_load_data_o,
  output logic [127:0] core_lane_o,
  output logic         core_enc_or_dec_o,
  input  logic         core_key_ready_i,
  input  logic         core_cipher_ready_i,
  input  logic [127:0] core_text_i
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_KEY_PULSE  = 3'd1,
    S_KEY_WAIT   = 3'd2,
    S_DATA_PULSE = 3'd3,
    S_DATA_WAIT  = 3'd4,
    S_RESP       = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q,    state_d;
  logic [127:0]     key_lat_q,  key_lat_d;   // key of the job in flight
  logic [127:0]     data_lat_q, data_lat_d;  // text of the job in flight
  logic             dec_q,      dec_d;       // direction of the job in flight
  logic [127:0]     key_q,      key_d;       // key currently expanded inside the core
  logic             key_vld_q,  key_vld_d;   // key_q is known to be loaded in the core
  logic [CNT_W-1:0] cnt_q,      cnt_d;       // cycles spent in the current WAIT state
  logic [127:0]     rsp_data_q, rsp_data_d;
  logic             rsp_err_q,  rsp_err_d;

  logic             key_hit;
  logic             cnt_zero;
  logic             cnt_timeout;

  // A cached key is reused only if it is still valid, identical, and not forced out.
  assign key_hit     = key_vld_q && (req_key_i == key_q) && !req_force_key_i;
  // The core's ready level from the previous operation is still visible for one cycle
  // after a load pulse, so the first WAIT cycle must not be trusted.
  assign cnt_zero    = (cnt_q == '0);
  assign cnt_timeout = (cnt_q == TIMEOUT_CNT);

  // Next-state and datapath updates for the job sequencer.
  always_comb begin
    // NOTE: every variable driven here gets a default first; a path that leaves one
    // unassigned would make synthesis infer a latch to hold its old value.
    state_d    = state_q;
    key_lat_d  = key_lat_q;
    data_lat_d = data_lat_q;
    dec_d      = dec_q;
    key_d      = key_q;
    key_vld_d  = key_vld_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          key_lat_d  = req_key_i;
          data_lat_d = req_data_i;
          dec_d      = req_dec_i;
          state_d    = key_hit ? S_DATA_PULSE : S_KEY_PULSE;
        end
      end

      S_KEY_PULSE: begin
        // The core's key is about to be overwritten, so the cache is no longer trustworthy.
        key_vld_d = 1'b0;
        cnt_d     = '0;
        state_d   = S_KEY_WAIT;
      end

      S_KEY_WAIT: begin
        if (!cnt_zero && core_key_ready_i) begin
          key_d     = key_lat_q;
          key_vld_d = 1'b1;
          state_d   = S_DATA_PULSE;
        end else if (cnt_timeout) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          key_vld_d  = 1'b0;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA_PULSE: begin
        cnt_d   = '0;
        state_d = S_DATA_WAIT;
      end

      S_DATA_WAIT: begin
        if (!cnt_zero && core_cipher_ready_i) begin
          rsp_data_d = core_text_i;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_timeout) begin
          // A core that stops answering may hold a corrupted key schedule.
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          key_vld_d  = 1'b0;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job and invalidates the key cache.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // values from before the edge, regardless of statement order.
    if (rst_i) begin
      state_q    <= S_IDLE;
      // NOTE: the wide job and cache registers are reset too; the key comparison and
      // the response output must read defined values straight after reset.
      key_lat_q  <= '0;
      data_lat_q <= '0;
      dec_q      <= 1'b0;
      key_q      <= '0;
      key_vld_q  <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_lat_q  <= key_lat_d;
      data_lat_q <= data_lat_d;
      dec_q      <= dec_d;
      key_q      <= key_d;
      key_vld_q  <= key_vld_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Core-side drive decoded from the registered state, so the pulses are glitch-free
  // and last exactly one cycle each.
  always_comb begin
    core_reset_key_o  = 1'b0;
    core_load_data_o  = 1'b0;
    core_lane_o       = '0;
    core_enc_or_dec_o = 1'b1;
    case (state_q)
      S_KEY_PULSE: begin
        core_reset_key_o = 1'b1;
        core_lane_o      = key_lat_q;
      end
      S_KEY_WAIT: begin
        core_lane_o = key_lat_q;
      end
      S_DATA_PULSE: begin
        core_load_data_o  = 1'b1;
        core_lane_o       = data_lat_q;
        core_enc_or_dec_o = ~dec_q;
      end
      S_DATA_WAIT: begin
        core_lane_o       = data_lat_q;
        core_enc_or_dec_o = ~dec_q;
      end
      default: begin
      end
    endcase
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_aes128_ctrl.sv
// tb_aes128_ctrl: randomized self-checking bench for aes128_ctrl.
// A stub core with programmable latency stands in for aes128. The job-level model
// predicts result, error flag, pulse counts and latency from the controller's rules.
module tb_aes128_ctrl;

  localparam int TO = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [127:0] req_key_i;
  logic [127:0] req_data_i;
  logic         req_dec_i;
  logic         req_force_key_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [127:0] rsp_data_o;
  logic         rsp_err_o;
  logic         busy_o;
  logic         core_reset_key_o;
  logic         core_load_data_o;
  logic [127:0] core_lane_o;
  logic         core_enc_or_dec_o;
  logic         core_key_ready_i    = 1'b0;
  logic         core_cipher_ready_i = 1'b0;
  logic [127:0] core_text_i         = '0;

  always #5 clk_i = ~clk_i;

  aes128_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(6)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_key_i           (req_key_i),
    .req_data_i          (req_data_i),
    .req_dec_i           (req_dec_i),
    .req_force_key_i     (req_force_key_i),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_ready_i         (rsp_ready_i),
    .rsp_data_o          (rsp_data_o),
    .rsp_err_o           (rsp_err_o),
    .busy_o              (busy_o),
    .core_reset_key_o    (core_reset_key_o),
    .core_load_data_o    (core_load_data_o),
    .core_lane_o         (core_lane_o),
    .core_enc_or_dec_o   (core_enc_or_dec_o),
    .core_key_ready_i    (core_key_ready_i),
    .core_cipher_ready_i (core_cipher_ready_i),
    .core_text_i         (core_text_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  endtask

  // Invertible stand-in for the cipher: enc = rotl13(d) ^ k, dec = rotr13(d ^ k).
  function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] d,
                                          input logic enc);
    logic [127:0] x;
    if (enc) begin
      core_f = {d[114:0], d[127:115]} ^ k;
    end else begin
      x      = d ^ k;
      core_f = {x[12:0], x[127:13]};
    end
  endfunction

  // ---------------- stub core ----------------
  // After a load pulse the old ready level stays up one more cycle, then drops, and
  // rises again <lat> cycles later (never, when stuck).
  int           k_lat = 1, d_lat = 1;
  bit           k_stuck = 1'b0, d_stuck = 1'b0;
  logic         k_pend = 1'b0, d_pend = 1'b0;
  int           k_rem = 0, d_rem = 0;
  logic [127:0] s_key = '0, s_data = '0;
  logic         s_enc = 1'b1;

  always @(posedge clk_i) begin
    if (core_reset_key_o) begin
      s_key  <= core_lane_o;
      k_pend <= 1'b1;
      k_rem  <= 0;
    end else if (k_pend) begin
      k_pend           <= 1'b0;
      core_key_ready_i <= 1'b0;
      k_rem            <= k_stuck ? 0 : k_lat;
    end else if (k_rem > 0) begin
      if (k_rem == 1) core_key_ready_i <= 1'b1;
      k_rem <= k_rem - 1;
    end

    if (core_load_data_o) begin
      s_data <= core_lane_o;
      s_enc  <= core_enc_or_dec_o;
      d_pend <= 1'b1;
      d_rem  <= 0;
    end else if (d_pend) begin
      d_pend              <= 1'b0;
      core_cipher_ready_i <= 1'b0;
      d_rem               <= d_stuck ? 0 : d_lat;
    end else if (d_rem > 0) begin
      if (d_rem == 1) begin
        core_cipher_ready_i <= 1'b1;
        core_text_i         <= core_f(s_key, s_data, s_enc);
      end
      d_rem <= d_rem - 1;
    end
  end

  // ---------------- job-level model state ----------------
  bit           m_vld = 1'b0;      // controller should hold a reusable key
  logic [127:0] m_key = '0;
  logic [127:0] exp_key = '0, exp_din = '0, exp_rsp = '0;
  bit           exp_dec = 1'b0, exp_err = 1'b0;
  int           exp_lat = 0;

  // ---------------- compare process ----------------
  int           cyc = 0, hs_cyc = 0, n_key = 0, n_data = 0;
  bit           first_rsp = 1'b0, key_phase = 1'b0, data_phase = 1'b0;
  bit           prev_key = 1'b0, prev_dat = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  logic [127:0] prev_rsp = '0;
  logic         prev_err = 1'b0;

  always @(negedge clk_i) begin
    cyc++;
    if (rst_i) begin
      first_rsp  = 1'b0;
      key_phase  = 1'b0;
      data_phase = 1'b0;
      prev_key   = 1'b0;
      prev_dat   = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (rsp_valid_o) begin
        key_phase  = 1'b0;
        data_phase = 1'b0;
      end
      if (core_reset_key_o) begin
        n_key++;
        check("key_pulse_one_cycle", 128'(prev_key), 128'(0));
        check("pulses_exclusive", 128'(core_load_data_o), 128'(0));
        key_phase = 1'b1;
      end
      if (core_load_data_o) begin
        n_data++;
        check("data_pulse_one_cycle", 128'(prev_dat), 128'(0));
        key_phase  = 1'b0;
        data_phase = 1'b1;
      end
      if (key_phase) check("key_lane", core_lane_o, exp_key);
      if (data_phase) begin
        check("data_lane", core_lane_o, exp_din);
        check("enc_or_dec", 128'(core_enc_or_dec_o), 128'(!exp_dec));
      end
      check("busy_vs_req_ready", 128'(busy_o), 128'(!req_ready_o));
      if (req_valid_i && req_ready_o) begin
        hs_cyc    = cyc;
        first_rsp = 1'b1;
      end
      if (rsp_valid_o) begin
        check("rsp_data", rsp_data_o, exp_rsp);
        check("rsp_err", 128'(rsp_err_o), 128'(exp_err));
        check("req_ready_in_resp", 128'(req_ready_o), 128'(0));
        if (first_rsp) begin
          check("latency", 128'(cyc - hs_cyc), 128'(exp_lat));
          first_rsp = 1'b0;
        end else if (prev_valid && !prev_ready) begin
          check("rsp_data_stable", rsp_data_o, prev_rsp);
          check("rsp_err_stable", 128'(rsp_err_o), 128'(prev_err));
        end
      end
      prev_key   = core_reset_key_o;
      prev_dat   = core_load_data_o;
      prev_valid = rsp_valid_o;
      prev_ready = rsp_ready_i;
      prev_rsp   = rsp_data_o;
      prev_err   = rsp_err_o;
    end
  end

  // ---------------- driver ----------------
  task automatic run_job(input logic [127:0] key, input logic [127:0] data, input bit dec,
                         input bit force_k, input int lk, input int ld, input bit ks,
                         input bit ds, input int bp, input bit poke,
                         output logic [127:0] got);
    bit miss, key_fail, done;
    int nk, nd, key0, dat0;
    miss     = !m_vld || (key != m_key) || force_k;
    key_fail = miss && ks;
    nk       = ks ? TO + 1 : lk + 2;
    nd       = ds ? TO + 1 : ld + 2;
    exp_key  = key;
    exp_din  = data;
    exp_dec  = dec;
    exp_err  = key_fail || ds;
    exp_rsp  = exp_err ? '0 : core_f(key, data, !dec);
    exp_lat  = 1 + (miss ? 1 + nk : 0) + (key_fail ? 0 : 1 + nd);
    k_lat    = lk;
    d_lat    = ld;
    k_stuck  = ks;
    d_stuck  = ds;
    key0     = n_key;
    dat0     = n_data;

    @(posedge clk_i);
    #1;
    req_key_i       = key;
    req_data_i      = data;
    req_dec_i       = dec;
    req_force_key_i = force_k;
    req_valid_i     = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk_i);
      if (req_ready_o) done = 1'b1;
    end
    if (!done) begin
      check("req_handshake_bound", 128'(0), 128'(1));
      finish_run();
    end
    @(posedge clk_i);
    #1;
    req_valid_i     = 1'b0;
    req_force_key_i = 1'b0;

    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) done = 1'b1;
    end
    if (!done) begin
      check("rsp_valid_bound", 128'(0), 128'(1));
      finish_run();
    end
    #1;
    if (poke) begin
      req_key_i   = ~key;
      req_valid_i = 1'b1;
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk_i);
      check("req_ready_low_while_rsp", 128'(req_ready_o), 128'(0));
    end
    #1;
    got         = rsp_data_o;
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("req_ready_after_rsp", 128'(req_ready_o), 128'(1));
    check("rsp_valid_cleared", 128'(rsp_valid_o), 128'(0));
    check("key_pulse_count", 128'(n_key - key0), 128'(miss));
    check("data_pulse_count", 128'(n_data - dat0), 128'(!key_fail));
    if (exp_err) begin
      m_vld = 1'b0;
    end else begin
      m_vld = 1'b1;
      m_key = key;
    end
  endtask

  // Start a job, reset the controller while it waits for the cipher, and check the abort.
  task automatic reset_mid_job(input logic [127:0] key, input logic [127:0] data);
    bit done;
    int dat0;
    exp_key = key;
    exp_din = data;
    exp_dec = 1'b0;
    k_lat   = 2;
    d_lat   = 20;
    k_stuck = 1'b0;
    d_stuck = 1'b0;
    dat0    = n_data;
    @(posedge clk_i);
    #1;
    req_key_i   = key;
    req_data_i  = data;
    req_dec_i   = 1'b0;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk_i);
      if (n_data != dat0) done = 1'b1;
    end
    check("reset_job_reached_data", 128'(done), 128'(1));
    repeat (3) @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("abort_busy", 128'(busy_o), 128'(0));
    check("abort_req_ready", 128'(req_ready_o), 128'(1));
    check("abort_rsp_valid", 128'(rsp_valid_o), 128'(0));
    check("abort_lane", core_lane_o, 128'(0));
    check("abort_enc", 128'(core_enc_or_dec_o), 128'(1));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    m_vld = 1'b0;
    repeat (40) @(posedge clk_i);
  endtask

  localparam logic [127:0] T1_KEY  = 128'h2B28AB09_7EAEF7CF_15D2154F_16A6883C;
  localparam logic [127:0] T1_DATA = 128'h4C6D7364_6F20756F_72696D6C_6570206F;
  localparam logic [127:0] K2      = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  initial begin
    logic [127:0] got, t1_res, pool [3];
    rst_i           = 1'b1;
    req_valid_i     = 1'b0;
    req_key_i       = '0;
    req_data_i      = '0;
    req_dec_i       = 1'b0;
    req_force_key_i = 1'b0;
    rsp_ready_i     = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_req_ready", 128'(req_ready_o), 128'(1));
    check("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
    check("rst_rsp_err", 128'(rsp_err_o), 128'(0));
    check("rst_rsp_data", rsp_data_o, 128'(0));
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_key_pulse", 128'(core_reset_key_o), 128'(0));
    check("rst_data_pulse", 128'(core_load_data_o), 128'(0));
    check("rst_lane", core_lane_o, 128'(0));
    check("rst_enc", 128'(core_enc_or_dec_o), 128'(1));

    // Hand-computed results that pin the reference transform.
    run_job('0, 128'h1, 1'b0, 1'b0, 3, 4, 1'b0, 1'b0, 0, 1'b0, got);
    check("lit_enc_bit0", got, 128'h2000);
    run_job('0, {1'b1, 127'b0}, 1'b0, 1'b0, 3, 5, 1'b0, 1'b0, 1, 1'b0, got);
    check("lit_enc_bit127", got, 128'h1000);
    run_job('0, 128'h2000, 1'b1, 1'b0, 3, 2, 1'b0, 1'b0, 0, 1'b0, got);
    check("lit_dec", got, 128'h1);
    run_job('1, '0, 1'b0, 1'b0, 6, 3, 1'b0, 1'b0, 2, 1'b0, got);
    check("lit_enc_ones_key", got, '1);

    // Miss, then two hits with the same result, then decrypt back with the cached key.
    run_job(T1_KEY, T1_DATA, 1'b0, 1'b0, 8, 9, 1'b0, 1'b0, 0, 1'b0, t1_res);
    run_job(T1_KEY, T1_DATA, 1'b0, 1'b0, 8, 9, 1'b0, 1'b0, 0, 1'b0, got);
    check("hit_same_result", got, t1_res);
    run_job(T1_KEY, T1_DATA, 1'b0, 1'b0, 8, 4, 1'b0, 1'b0, 1, 1'b0, got);
    check("hit_same_result2", got, t1_res);
    run_job(T1_KEY, t1_res, 1'b1, 1'b0, 8, 6, 1'b0, 1'b0, 0, 1'b0, got);
    check("dec_roundtrip", got, T1_DATA);

    // Forced reload, different key, and return to the first key.
    run_job(T1_KEY, T1_DATA, 1'b0, 1'b1, 5, 5, 1'b0, 1'b0, 0, 1'b0, got);
    run_job(K2, T1_DATA, 1'b0, 1'b0, 4, 7, 1'b0, 1'b0, 0, 1'b0, got);
    run_job(T1_KEY, T1_DATA, 1'b0, 1'b0, 4, 7, 1'b0, 1'b0, 0, 1'b0, got);

    // Long backpressure with a competing request held up meanwhile.
    run_job(T1_KEY, T1_DATA, 1'b0, 1'b0, 5, 5, 1'b0, 1'b0, 7, 1'b1, got);

    // Ready arriving on the last counter value, then both kinds of timeout.
    run_job(K2, T1_DATA, 1'b0, 1'b0, TO - 1, TO - 1, 1'b0, 1'b0, 0, 1'b0, got);
    run_job(K2, T1_DATA, 1'b0, 1'b0, 3, 3, 1'b0, 1'b1, 2, 1'b0, got);
    run_job(K2, T1_DATA, 1'b0, 1'b0, 3, 3, 1'b0, 1'b0, 0, 1'b0, got);
    run_job(T1_KEY, T1_DATA, 1'b0, 1'b0, 3, 3, 1'b1, 1'b0, 1, 1'b0, got);

    // Reset during the data wait; the next job has to reload its key.
    reset_mid_job(T1_KEY, T1_DATA);
    run_job(T1_KEY, T1_DATA, 1'b0, 1'b0, 3, 3, 1'b0, 1'b0, 0, 1'b0, got);
    check("after_reset_result", got, t1_res);

    // Randomized jobs from a small key pool so hits and misses both occur.
    pool[0] = T1_KEY;
    pool[1] = K2;
    pool[2] = {$urandom, $urandom, $urandom, $urandom};
    for (int j = 0; j < 40; j++) begin
      logic [127:0] rk, rd;
      rk = pool[$urandom_range(0, 2)];
      rd = {$urandom, $urandom, $urandom, $urandom};
      run_job(rk, rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
              $urandom_range(1, 12), $urandom_range(1, 12),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
    end

    repeat (2) @(posedge clk_i);
    finish_run();
  end

  // Global bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_errors++;
    finish_run();
  end

endmodule
